banco_nos_ativos: RTL and testbench

- Bank of NUM_NA active-node (NA) slot registers. It is the responder side of the active-node manager's command interface.
- Consumes the registered desativar/atualizar commands and the one-hot slot-enable from the manager. It stores address, predecessor, distance and lowest-neighbour cost per slot.
- It returns the flattened slot address and active vectors that the manager uses for hit detection.
- A sequential scan engine finds the active slot with the lowest estimated cost (distancia + menor_vizinho) for the path-expansion stage.

---
 rtl/banco_nos_ativos.sv | 148 ++++++++++++++
 tb/tb_banco_nos_ativos.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/banco_nos_ativos.sv
// banco_nos_ativos: active-node slot bank with a sequential lowest-cost scan engine
module banco_nos_ativos #(
    parameter int NUM_NA          = 8,
    parameter int ADDR_WIDTH      = 5,
    parameter int DISTANCIA_WIDTH = 5,
    parameter int CUSTO_WIDTH     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           desativar_in,
    input  logic                           atualizar_in,
    input  logic [NUM_NA-1:0]              habilitar_in,
    input  logic [ADDR_WIDTH-1:0]          endereco_in,
    input  logic [ADDR_WIDTH-1:0]          anterior_in,
    input  logic [CUSTO_WIDTH-1:0]         menor_vizinho_in,
    input  logic [DISTANCIA_WIDTH-1:0]     distancia_in,
    input  logic                           buscar_in,
    output logic [ADDR_WIDTH*NUM_NA-1:0]   na_endereco_o,
    output logic [NUM_NA-1:0]              na_ativo_o,
    output logic [$clog2(NUM_NA+1)-1:0]    na_livres_o,
    output logic                           ocupado_o,
    output logic                           busca_feita_o,
    output logic                           menor_encontrado_o,
    output logic [NUM_NA-1:0]              menor_indice_o,
    output logic [ADDR_WIDTH-1:0]          menor_endereco_o,
    output logic [ADDR_WIDTH-1:0]          menor_anterior_o,
    output logic [DISTANCIA_WIDTH:0]       menor_custo_o
);
    localparam int IW = $clog2(NUM_NA);
    localparam int CW = DISTANCIA_WIDTH + 1;
    localparam int LW = $clog2(NUM_NA + 1);

    typedef enum logic [1:0] {OCIOSO, VARRENDO, PRONTO} estado_t;

    estado_t estado, prox;
    logic [ADDR_WIDTH-1:0]      endereco  [NUM_NA];
    logic [ADDR_WIDTH-1:0]      anterior  [NUM_NA];
    logic [DISTANCIA_WIDTH-1:0] distancia [NUM_NA];
    logic [CUSTO_WIDTH-1:0]     vizinho   [NUM_NA];
    logic [NUM_NA-1:0]          ativo;
    logic                       um_quente;
    logic [IW-1:0]              idx, melhor_idx, f_idx;
    logic                       melhor_valido, toma, f_valido;
    logic [CW-1:0]              melhor_custo, custo_atual, f_custo;
    logic [ADDR_WIDTH-1:0]      melhor_end, melhor_ant, f_end, f_ant;

    assign um_quente = |habilitar_in && ~|(habilitar_in & (habilitar_in - 1'b1));
    assign na_ativo_o = ativo;
    assign ocupado_o = estado == VARRENDO;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ativo <= '0;
            for (int i = 0; i < NUM_NA; i++) begin
                endereco[i]  <= '0;
                anterior[i]  <= '0;
                distancia[i] <= '0;
                vizinho[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_NA; i++) begin
                if (desativar_in && habilitar_in[i])
                    ativo[i] <= 1'b0;
                else if (atualizar_in && !desativar_in && um_quente && habilitar_in[i]) begin
                    if (!ativo[i]) begin
                        ativo[i]     <= 1'b1;
                        endereco[i]  <= endereco_in;
                        anterior[i]  <= anterior_in;
                        distancia[i] <= distancia_in;
                        vizinho[i]   <= menor_vizinho_in;
                    end else if (endereco[i] == endereco_in && distancia_in < distancia[i]) begin
                        anterior[i]  <= anterior_in;
                        distancia[i] <= distancia_in;
                        vizinho[i]   <= menor_vizinho_in;
                    end
                end
            end
        end
    end

    always_comb begin
        na_livres_o = LW'(NUM_NA);
        for (int i = 0; i < NUM_NA; i++)
            na_livres_o = na_livres_o - LW'(ativo[i]);
        for (int i = 0; i < NUM_NA; i++)
            na_endereco_o[ADDR_WIDTH*i +: ADDR_WIDTH] = endereco[i];
    end

    // Live read of the slot under the scan pointer, merged with best-so-far
    assign custo_atual = CW'(distancia[idx]) + CW'(vizinho[idx]);
    assign toma        = ativo[idx] && (!melhor_valido || custo_atual < melhor_custo);
    assign f_valido    = toma || melhor_valido;
    assign f_idx       = toma ? idx : melhor_idx;
    assign f_custo     = toma ? custo_atual : melhor_custo;
    assign f_end       = toma ? endereco[idx] : melhor_end;
    assign f_ant       = toma ? anterior[idx] : melhor_ant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) estado <= OCIOSO;
        else     estado <= prox;
    end

    always_comb begin
        prox = estado;
        case (estado)
            OCIOSO:   prox = buscar_in ? VARRENDO : OCIOSO;
            VARRENDO: prox = idx == IW'(NUM_NA - 1) ? PRONTO : VARRENDO;
            default:  prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx                <= '0;
            melhor_valido      <= 1'b0;
            melhor_idx         <= '0;
            melhor_custo       <= '0;
            melhor_end         <= '0;
            melhor_ant         <= '0;
            busca_feita_o      <= 1'b0;
            menor_encontrado_o <= 1'b0;
            menor_indice_o     <= '0;
            menor_endereco_o   <= '0;
            menor_anterior_o   <= '0;
            menor_custo_o      <= '0;
        end else begin
            busca_feita_o <= estado == PRONTO;
            if (estado == OCIOSO && buscar_in) begin
                idx           <= '0;
                melhor_valido <= 1'b0;
            end else if (estado == VARRENDO) begin
                idx           <= idx + 1'b1;
                melhor_valido <= f_valido;
                melhor_idx    <= f_idx;
                melhor_custo  <= f_custo;
                melhor_end    <= f_end;
                melhor_ant    <= f_ant;
                if (idx == IW'(NUM_NA - 1)) begin
                    menor_encontrado_o <= f_valido;
                    menor_indice_o     <= f_valido ? NUM_NA'(1) << f_idx : '0;
                    menor_endereco_o   <= f_valido ? f_end : '0;
                    menor_anterior_o   <= f_valido ? f_ant : '0;
                    menor_custo_o      <= f_valido ? f_custo : '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_banco_nos_ativos.sv
// tb_banco_nos_ativos: scoreboard bench for the active-node slot bank and its min-cost scan
module tb_banco_nos_ativos;
    logic        clk = 0, rst = 1;
    logic        desativar_in = 0, atualizar_in = 0, buscar_in = 0;
    logic [7:0]  habilitar_in = 0;
    logic [4:0]  endereco_in = 0, anterior_in = 0, distancia_in = 0;
    logic [3:0]  menor_vizinho_in = 0;
    logic [39:0] na_endereco_o;
    logic [7:0]  na_ativo_o, menor_indice_o;
    logic [3:0]  na_livres_o;
    logic        ocupado_o, busca_feita_o, menor_encontrado_o;
    logic [4:0]  menor_endereco_o, menor_anterior_o;
    logic [5:0]  menor_custo_o;

    int checks = 0, errors = 0;

    typedef struct {
        logic       enc;
        logic [7:0] ind;
        logic [4:0] e;
        logic [4:0] a;
        logic [5:0] c;
    } res_t;
    res_t sb[$];

    bit m_at[8];
    int m_end[8], m_ant[8], m_dist[8], m_viz[8];

    banco_nos_ativos dut (
        .clk(clk), .rst(rst), .desativar_in(desativar_in), .atualizar_in(atualizar_in),
        .habilitar_in(habilitar_in), .endereco_in(endereco_in), .anterior_in(anterior_in),
        .menor_vizinho_in(menor_vizinho_in), .distancia_in(distancia_in), .buscar_in(buscar_in),
        .na_endereco_o(na_endereco_o), .na_ativo_o(na_ativo_o), .na_livres_o(na_livres_o),
        .ocupado_o(ocupado_o), .busca_feita_o(busca_feita_o),
        .menor_encontrado_o(menor_encontrado_o), .menor_indice_o(menor_indice_o),
        .menor_endereco_o(menor_endereco_o), .menor_anterior_o(menor_anterior_o),
        .menor_custo_o(menor_custo_o)
    );

    always #5 clk = ~clk;

    task automatic verifica(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelo_reset();
        for (int i = 0; i < 8; i++) begin
            m_at[i] = 0; m_end[i] = 0; m_ant[i] = 0; m_dist[i] = 0; m_viz[i] = 0;
        end
    endtask

    function automatic res_t modelo_busca();
        res_t r;
        int b = -1, bc = 0;
        for (int i = 0; i < 8; i++)
            if (m_at[i] && (b < 0 || m_dist[i] + m_viz[i] < bc)) begin
                b = i; bc = m_dist[i] + m_viz[i];
            end
        r.enc = b >= 0;
        r.ind = b >= 0 ? 8'(1 << b) : 8'd0;
        r.e   = b >= 0 ? 5'(m_end[b]) : 5'd0;
        r.a   = b >= 0 ? 5'(m_ant[b]) : 5'd0;
        r.c   = b >= 0 ? 6'(bc) : 6'd0;
        return r;
    endfunction

    task automatic confere_na(string tag);
        logic [39:0] ev;
        logic [7:0]  av;
        int livres = 8;
        for (int i = 0; i < 8; i++) begin
            ev[5*i +: 5] = 5'(m_end[i]);
            av[i] = m_at[i];
            if (m_at[i]) livres--;
        end
        verifica({tag, ".ativo"}, 64'(na_ativo_o), 64'(av));
        verifica({tag, ".livres"}, 64'(na_livres_o), 64'(livres));
        verifica({tag, ".endereco"}, 64'(na_endereco_o), 64'(ev));
    endtask

    task automatic comando(string tag, bit des, bit atu, logic [7:0] hab, int e, int a, int v, int d);
        bit oh;
        @(negedge clk);
        desativar_in = des; atualizar_in = atu; habilitar_in = hab;
        endereco_in = 5'(e); anterior_in = 5'(a); menor_vizinho_in = 4'(v); distancia_in = 5'(d);
        @(posedge clk);
        oh = hab != 0 && (hab & (hab - 8'd1)) == 0;
        for (int i = 0; i < 8; i++)
            if (des && hab[i]) m_at[i] = 0;
            else if (atu && !des && oh && hab[i]) begin
                if (!m_at[i]) begin
                    m_at[i] = 1; m_end[i] = e; m_ant[i] = a; m_dist[i] = d; m_viz[i] = v;
                end else if (m_end[i] == e && d < m_dist[i]) begin
                    m_ant[i] = a; m_dist[i] = d; m_viz[i] = v;
                end
            end
        #1;
        desativar_in = 0; atualizar_in = 0; habilitar_in = 0;
        confere_na(tag);
    endtask

    task automatic varre(string tag);
        res_t x, y;
        int k = 0, occ = 0;
        bit visto = 0;
        @(negedge clk);
        buscar_in = 1;
        sb.push_back(modelo_busca());
        @(posedge clk);
        #1 buscar_in = 0;
        while (k < 40 && !visto) begin
            @(negedge clk);
            if (busca_feita_o) visto = 1;
            else begin
                occ += int'(ocupado_o);
                k++;
            end
        end
        verifica({tag, ".latencia"}, 64'(k), 64'd9);
        verifica({tag, ".ocupado"}, 64'(occ), 64'd8);
        if (sb.size() == 0) verifica({tag, ".fila"}, 64'd0, 64'd1);
        else begin
            y = sb.pop_front();
            x.enc = menor_encontrado_o; x.ind = menor_indice_o;
            x.e = menor_endereco_o; x.a = menor_anterior_o; x.c = menor_custo_o;
            verifica({tag, ".encontrado"}, 64'(x.enc), 64'(y.enc));
            verifica({tag, ".indice"}, 64'(x.ind), 64'(y.ind));
            verifica({tag, ".endereco"}, 64'(x.e), 64'(y.e));
            verifica({tag, ".anterior"}, 64'(x.a), 64'(y.a));
            verifica({tag, ".custo"}, 64'(x.c), 64'(y.c));
        end
        @(negedge clk);
        verifica({tag, ".pulso"}, 64'(busca_feita_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vistos;
        modelo_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 0;
        confere_na("reset");
        verifica("reset.ocupado", 64'(ocupado_o), 64'd0);
        verifica("reset.encontrado", 64'(menor_encontrado_o), 64'd0);
        vistos = 0;
        repeat (5) begin
            @(negedge clk);
            vistos += int'(busca_feita_o);
        end
        verifica("ocioso.feita", 64'(vistos), 64'd0);
        varre("vazio");

        comando("t2.carga", 0, 1, 8'b100, 7, 1, 3, 10);
        comando("t2.maior", 0, 1, 8'b100, 7, 2, 3, 12);
        varre("t2.mantem");
        comando("t2.menor", 0, 1, 8'b100, 7, 4, 3, 6);
        varre("t2.reduz");
        comando("t2.outro", 0, 1, 8'b100, 9, 5, 0, 1);
        comando("t2.igual", 0, 1, 8'b100, 7, 6, 0, 6);
        comando("t2.limpa", 1, 0, 8'b100, 0, 0, 0, 0);

        comando("t3.s0", 0, 1, 8'b00000001, 1, 11, 3, 6);
        comando("t3.s3", 0, 1, 8'b00001000, 3, 13, 3, 2);
        comando("t3.s5", 0, 1, 8'b00100000, 5, 15, 1, 4);
        varre("t3.empate");

        comando("t4.desat", 1, 0, 8'b00101000, 0, 0, 0, 0);
        verifica("t4.ativo", 64'(na_ativo_o), 64'h01);
        verifica("t4.livres", 64'(na_livres_o), 64'd7);
        varre("t4.busca");

        comando("t5.ambos", 1, 1, 8'b00000010, 10, 0, 0, 1);
        comando("t5.dois", 0, 1, 8'b00000011, 11, 0, 0, 1);
        comando("t5.zero", 0, 1, 8'b00000000, 12, 0, 0, 1);
        verifica("t5.ativo", 64'(na_ativo_o), 64'h01);

        comando("max.s7", 0, 1, 8'b10000000, 31, 30, 15, 31);
        comando("max.d0", 1, 0, 8'b00000001, 0, 0, 0, 0);
        varre("max.custo");

        @(negedge clk) buscar_in = 1;
        @(posedge clk);
        #1 buscar_in = 0;
        repeat (5) @(negedge clk);
        rst = 1;
        modelo_reset();
        #1;
        confere_na("t6.rst");
        verifica("t6.ocupado", 64'(ocupado_o), 64'd0);
        verifica("t6.encontrado", 64'(menor_encontrado_o), 64'd0);
        verifica("t6.indice", 64'(menor_indice_o), 64'd0);
        verifica("t6.custo", 64'(menor_custo_o), 64'd0);
        @(negedge clk) rst = 0;
        vistos = 0;
        repeat (15) begin
            @(negedge clk);
            vistos += int'(busca_feita_o);
        end
        verifica("t6.sem_pulso", 64'(vistos), 64'd0);
        varre("t6.nova");

        verifica("fila.vazia", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
